// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver (8N1, LSB first, idle high) with 3-sample mid-bit majority
//   voting, feeding a first-word-fall-through byte FIFO drained by valid/ready.
//
// Ports
//   clk_i             system clock, rising edge
//   rst_i             asynchronous, active-high reset
//   uart_rx_data_i    raw serial line, asynchronous to clk_i
//   data_o            FIFO head byte (0x00 while empty)
//   valid_o           FIFO not empty
//   ready_i           consumer accepts head; pop on valid_o & ready_i
//   fifo_count_o      bytes currently stored
//   uart_rx_active_o  frame reception in progress
//   frame_err_o       one-cycle pulse: stop bit sampled low
//   overrun_err_o     one-cycle pulse: good byte dropped, FIFO full
//
// Receive FSM
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | line high, waiting for a start edge
//   START      | qualifying the start bit at half a bit period
//   DATA       | sampling 8 data bits, one per bit period
//   STOP       | sampling the stop bit; push byte or flag framing error
//   WAIT_HIGH  | after a framing error, hold off until the line is high
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        uart_rx_data_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        uart_rx_active_o,
    output logic                        frame_err_o,
    output logic                        overrun_err_o
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] DEPTH     = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [2:0] hist_q,  hist_d;
    logic       maj;

    always_comb begin
        sync1_d = uart_rx_data_i;
        sync2_d = sync1_q;
        hist_d  = {hist_q[1:0], sync2_q};
    end

    assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                 (hist_q[1] & hist_q[2]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic             push;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    bit_idx_d = '0;
                    // A start bit that has gone high again by mid-bit is a glitch.
                    state_d   = maj ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shreg_d[bit_idx_q] = maj;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    // Stays in DATA between bits, so restart the bit timer here.
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    if (maj) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              overrun_err_q, overrun_err_d;
    logic              full, not_empty, pop, push_ok;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH);
    assign pop       = not_empty & ready_i;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_ok   = push & (~full | pop);

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overrun_err_d = push & full & ~pop;

        if (push_ok) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; data_o is masked while empty instead.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_o           = not_empty ? mem_q[rd_ptr_q] : 8'h00;
    assign valid_o          = not_empty;
    assign fifo_count_o     = count_q;
    assign uart_rx_active_o = (state_q == ST_START) || (state_q == ST_DATA) ||
                              (state_q == ST_STOP);
    assign frame_err_o      = frame_err_q;
    assign overrun_err_o    = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=8, 10 ns clock.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       uart_rx_data_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] fifo_count_o;
    logic       uart_rx_active_o;
    logic       frame_err_o;
    logic       overrun_err_o;

    uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .uart_rx_data_i   (uart_rx_data_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .fifo_count_o     (fifo_count_o),
        .uart_rx_active_o (uart_rx_active_o),
        .frame_err_o      (frame_err_o),
        .overrun_err_o    (overrun_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Event counters and popped-byte log, sampled mid-cycle.
    int         valid_cyc = 0;
    int         act_cyc   = 0;
    int         fe_cyc    = 0;
    int         ov_cyc    = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk_i) begin
        if (valid_o) valid_cyc <= valid_cyc + 1;
        if (uart_rx_active_o) act_cyc <= act_cyc + 1;
        if (frame_err_o) fe_cyc <= fe_cyc + 1;
        if (overrun_err_o) ov_cyc <= ov_cyc + 1;
        if (valid_o && ready_i) rx_q.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input realtime bt,
                              input logic stop_lvl, input realtime stop_t);
        uart_rx_data_i = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            uart_rx_data_i = b[i];
            #(bt);
        end
        uart_rx_data_i = stop_lvl;
        #(stop_t);
        uart_rx_data_i = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_valid"},  valid_o, 0);
        check({pfx, "_count"},  fifo_count_o, 0);
        check({pfx, "_data"},   data_o, 8'h00);
        check({pfx, "_active"}, uart_rx_active_o, 0);
        check({pfx, "_ferr"},   frame_err_o, 0);
        check({pfx, "_oerr"},   overrun_err_o, 0);
    endtask

    task automatic drain(input string tag, input logic [7:0] first, input int n);
        ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, valid_o, 1);
            check({tag, "_data"}, data_o, first + 8'(i));
            tick();
        end
        check({tag, "_empty"}, valid_o, 0);
        check({tag, "_count0"}, fifo_count_o, 0);
    endtask

    int  a0, v0, f0, o0;
    bit  found;

    initial begin
        // Reset state
        idle(3);
        check_reset_outputs("rst");
        rst_i = 1'b0;
        idle(5);

        // 1. Single frame, consumer always ready
        ready_i = 1'b1;
        rx_q.delete();
        a0 = act_cyc; v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'hA5, 160.0, 1'b1, 160.0);
        idle(20);
        check("t1_npop",   rx_q.size(), 1);
        check("t1_byte",   rx_at(0), 8'hA5);
        check("t1_vcyc",   valid_cyc - v0, 1);
        check("t1_active", act_cyc - a0, 152);
        check("t1_ferr",   fe_cyc - f0, 0);
        check("t1_oerr",   ov_cyc - o0, 0);
        check("t1_count",  fifo_count_o, 0);

        // 2. Glitch rejection
        rx_q.delete();
        a0 = act_cyc; f0 = fe_cyc;
        uart_rx_data_i = 1'b0;
        #40;
        uart_rx_data_i = 1'b1;
        idle(30);
        check("t2_active", act_cyc - a0, 8);
        check("t2_npop",   rx_q.size(), 0);
        check("t2_count",  fifo_count_o, 0);
        check("t2_ferr",   fe_cyc - f0, 0);

        // 3. Framing error with a long low stop, then a good frame
        rx_q.delete();
        a0 = act_cyc; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'h3C, 160.0, 1'b0, 500.0);
        idle(40);
        check("t3_ferr",   fe_cyc - f0, 1);
        check("t3_active", act_cyc - a0, 152);
        check("t3_npop",   rx_q.size(), 0);
        check("t3_count",  fifo_count_o, 0);
        check("t3_oerr",   ov_cyc - o0, 0);
        send_frame(8'h81, 160.0, 1'b1, 160.0);
        idle(20);
        check("t3_npop2",  rx_q.size(), 1);
        check("t3_byte2",  rx_at(0), 8'h81);
        check("t3_ferr2",  fe_cyc - f0, 1);

        // 4. Overrun on the 9th back-to-back frame, then drain
        ready_i = 1'b0;
        f0 = fe_cyc; o0 = ov_cyc;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 160.0, 1'b1, 160.0);
        idle(20);
        check("t4_count", fifo_count_o, 8);
        check("t4_oerr",  ov_cyc - o0, 1);
        check("t4_ferr",  fe_cyc - f0, 0);
        drain("t4_drain", 8'h00, 8);

        // 5a. Back-to-back frames at +3 % and -3 % baud
        rx_q.delete();
        send_frame(8'h55, 155.3, 1'b1, 155.3);
        send_frame(8'hAA, 155.3, 1'b1, 155.3);
        idle(20);
        check("t5_fast_n",  rx_q.size(), 2);
        check("t5_fast_b0", rx_at(0), 8'h55);
        check("t5_fast_b1", rx_at(1), 8'hAA);
        rx_q.delete();
        send_frame(8'h55, 164.8, 1'b1, 164.8);
        send_frame(8'hAA, 164.8, 1'b1, 164.8);
        idle(20);
        check("t5_slow_n",  rx_q.size(), 2);
        check("t5_slow_b0", rx_at(0), 8'h55);
        check("t5_slow_b1", rx_at(1), 8'hAA);

        // 5b. Push into a full FIFO together with a pop
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 160.0, 1'b1, 160.0);
        idle(40);
        check("t5_full", fifo_count_o, 8);
        o0 = ov_cyc;
        found = 1'b0;
        fork
            send_frame(8'h18, 160.0, 1'b1, 160.0);
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    tick();
                    if (uart_rx_active_o) found = 1'b1;
                end
                check("t5_start_seen", found, 1);
                if (found) begin
                    // Active lasts 152 cycles; the push lands on the edge
                    // ending the last of them.
                    idle(151);
                    check("t5_last_active", uart_rx_active_o, 1);
                    ready_i = 1'b1;
                    tick();
                    ready_i = 1'b0;
                    check("t5_after_active", uart_rx_active_o, 0);
                    check("t5_after_count",  fifo_count_o, 8);
                    check("t5_after_head",   data_o, 8'h11);
                end
            end
        join
        idle(20);
        check("t5_no_oerr", ov_cyc - o0, 0);
        drain("t5_drain", 8'h11, 8);

        // 6. Reset in the middle of a frame with bytes queued
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'h31 + 8'(i), 160.0, 1'b1, 160.0);
        idle(20);
        check("t6_queued", fifo_count_o, 3);
        f0 = fe_cyc;
        fork
            send_frame(8'hF0, 160.0, 1'b1, 160.0);
            begin
                #860;
                rst_i = 1'b1;
                #15;
                check_reset_outputs("t6_in_rst");
                #15;
                rst_i = 1'b0;
            end
        join
        idle(20);
        check("t6_count_after", fifo_count_o, 0);
        check("t6_idle_after",  uart_rx_active_o, 0);
        ready_i = 1'b1;
        rx_q.delete();
        send_frame(8'h12, 160.0, 1'b1, 160.0);
        idle(20);
        check("t6_npop", rx_q.size(), 1);
        check("t6_byte", rx_at(0), 8'h12);
        check("t6_ferr", fe_cyc - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
